// File: rtl/mul_seq16_ctrl.sv
// rtl/mul_seq16_ctrl.sv - 16x16 unsigned multiply sequenced over one shared 8x8 core
// Optional MUL_SEQ_SKIP_ZERO_EN: partials with a zero operand half are never issued.
module mul_seq16_ctrl #(
    parameter int SETTLE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_res,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] a_q, b_q;
    logic [31:0] acc;
    logic [1:0]  k;
    logic [7:0]  cnt;
    logic [3:0]  in_mask, run_mask;
    logic [2:0]  first_k, next_k;
    logic [4:0]  shift;
    logic        boundary;

`ifdef MUL_SEQ_SKIP_ZERO_EN
    function automatic logic [3:0] mask_of(input logic [15:0] a, input logic [15:0] b);
        mask_of = {(|a[15:8]) & (|b[15:8]), (|a[7:0]) & (|b[15:8]),
                   (|a[15:8]) & (|b[7:0]),  (|a[7:0]) & (|b[7:0])};
    endfunction

    assign in_mask  = mask_of(in_a, in_b);
    assign run_mask = mask_of(a_q, b_q);
`else
    assign in_mask  = 4'b1111;
    assign run_mask = 4'b1111;
`endif

    // Lowest issued partial index >= start; 4 means none remain.
    function automatic logic [2:0] find_from(input logic [3:0] m, input logic [2:0] start);
        find_from = 3'd4;
        for (int i = 3; i >= 0; i--)
            if (m[i] && (3'(i) >= start)) find_from = 3'(i);
    endfunction

    function automatic logic [7:0] sel_a(input logic [15:0] a, input logic [1:0] kk);
        sel_a = kk[0] ? a[15:8] : a[7:0];
    endfunction

    function automatic logic [7:0] sel_b(input logic [15:0] b, input logic [1:0] kk);
        sel_b = kk[1] ? b[15:8] : b[7:0];
    endfunction

    assign first_k  = find_from(in_mask, 3'd0);
    assign next_k   = find_from(run_mask, {1'b0, k} + 3'd1);
    assign boundary = (state == RUN) && (cnt == 8'(SETTLE - 1));
    assign shift    = {k[1] & k[0], k[1] ^ k[0], 3'b000};
    assign out_res  = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = first_k[2] ? DONE : RUN;
            RUN:  if (boundary && next_k[2]) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // mul_res is only meaningful at a boundary edge, after SETTLE held cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            k     <= '0;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_q <= in_a;
                b_q <= in_b;
                acc <= '0;
                cnt <= '0;
                if (!first_k[2]) begin
                    k     <= first_k[1:0];
                    mul_a <= sel_a(in_a, first_k[1:0]);
                    mul_b <= sel_b(in_b, first_k[1:0]);
                end
            end
        end else if (state == RUN) begin
            if (boundary) begin
                acc <= acc + ({16'd0, mul_res} << shift);
                cnt <= '0;
                if (!next_k[2]) begin
                    k     <= next_k[1:0];
                    mul_a <= sel_a(a_q, next_k[1:0]);
                    mul_b <= sel_b(b_q, next_k[1:0]);
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule
